sd_cmd_engine: RTL and testbench

- Command-line engine that feeds sd_bus_master's CMD path.
- Accepts a command (index, argument, response type) from the host controller.
- Serialises the 48-bit SD command frame with the CRC7 it generates onto the CMD line, then captures and checks the 48-bit response or flags a timeout.
- Bit timing comes from sd_bus_master's SD-clock edge strobes; this block never generates sdio_clk itself.

---
 rtl/sd_cmd_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command with CRC7, then captures/checks the 48-bit response or times out.
// Bit timing comes only from tx/rx strobes; cmd_ready is low from accept until NCC_CLKS tx_strobes after completion.
module sd_cmd_engine #(
    parameter int TIMEOUT_CLKS = 64,
    parameter int NCC_CLKS     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_strobe,
    input  logic        rx_strobe,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    output logic        cmd_out,
    output logic        cmd_oe,
    input  logic        cmd_in,
    output logic        resp_valid,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        resp_err,
    output logic        resp_timeout
);

    localparam int CNT_MAX = (TIMEOUT_CLKS > NCC_CLKS)
                           ? ((TIMEOUT_CLKS > 48) ? TIMEOUT_CLKS : 48)
                           : ((NCC_CLKS > 48) ? NCC_CLKS : 48);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_CRC  = CNT_W'(40);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(47);
    localparam logic [CNT_W-1:0] BIT_REL  = CNT_W'(48);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] NCC_LAST = CNT_W'(NCC_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [39:0]      sr_q, sr_d;
    logic [6:0]       crc_q, crc_d;
    logic [6:0]       rcrc_q, rcrc_d;
    logic [1:0]       type_q, type_d;
    logic [5:0]       idx_q, idx_d;
    logic             cmd_out_q, cmd_out_d;
    logic             cmd_oe_q, cmd_oe_d;
    logic             resp_valid_q, resp_valid_d;
    logic [5:0]       resp_index_q, resp_index_d;
    logic [31:0]      resp_arg_q, resp_arg_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_timeout_q, resp_timeout_d;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sr_d           = sr_q;
        crc_d          = crc_q;
        rcrc_d         = rcrc_q;
        type_d         = type_q;
        idx_d          = idx_q;
        cmd_out_d      = cmd_out_q;
        cmd_oe_d       = cmd_oe_q;
        resp_valid_d   = 1'b0;
        resp_index_d   = resp_index_q;
        resp_arg_d     = resp_arg_q;
        resp_err_d     = resp_err_q;
        resp_timeout_d = resp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    idx_d   = cmd_index;
                    type_d  = resp_type;
                    sr_d    = {2'b01, cmd_index, cmd_arg};
                    crc_d   = 7'h00;
                    cnt_d   = '0;
                    state_d = S_TX;
                end
            end
            S_TX: begin
                if (tx_strobe) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q < BIT_CRC) begin
                        cmd_oe_d  = 1'b1;
                        cmd_out_d = sr_q[39];
                        sr_d      = {sr_q[38:0], 1'b0};
                        crc_d     = crc7_next(crc_q, sr_q[39]);
                    end else if (cnt_q < BIT_END) begin
                        cmd_out_d = crc_q[6];
                        crc_d     = {crc_q[5:0], 1'b0};
                    end else if (cnt_q == BIT_END) begin
                        cmd_out_d = 1'b1;
                    end else begin
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                        cnt_d     = '0;
                        crc_d     = 7'h00;
                        if (type_q == 2'b00) begin
                            resp_valid_d   = 1'b1;
                            resp_err_d     = 1'b0;
                            resp_timeout_d = 1'b0;
                            state_d        = S_RECOVER;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (rx_strobe) begin
                    if (!cmd_in) begin
                        // Start bit is a zero, so it leaves the zero-seeded CRC untouched.
                        cnt_d   = CNT_W'(1);
                        state_d = S_RX;
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d          = '0;
                        resp_valid_d   = 1'b1;
                        resp_err_d     = 1'b0;
                        resp_timeout_d = 1'b1;
                        state_d        = S_RECOVER;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RX: begin
                if (rx_strobe) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q < BIT_CRC) begin
                        sr_d  = {sr_q[38:0], cmd_in};
                        crc_d = crc7_next(crc_q, cmd_in);
                    end else if (cnt_q < BIT_END) begin
                        rcrc_d = {rcrc_q[5:0], cmd_in};
                    end else begin
                        // sr_q[38] is the transmission bit, [37:32] index, [31:0] argument.
                        resp_err_d = !cmd_in || sr_q[38] ||
                                     ((type_q != 2'b10) &&
                                      ((rcrc_q != crc_q) || (sr_q[37:32] != idx_q)));
                        resp_index_d   = sr_q[37:32];
                        resp_arg_d     = sr_q[31:0];
                        resp_timeout_d = 1'b0;
                        resp_valid_d   = 1'b1;
                        cnt_d          = '0;
                        state_d        = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                if (tx_strobe) begin
                    if (cnt_q == NCC_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            sr_q           <= '0;
            crc_q          <= '0;
            rcrc_q         <= '0;
            type_q         <= '0;
            idx_q          <= '0;
            cmd_out_q      <= 1'b1;
            cmd_oe_q       <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_index_q   <= '0;
            resp_arg_q     <= '0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sr_q           <= sr_d;
            crc_q          <= crc_d;
            rcrc_q         <= rcrc_d;
            type_q         <= type_d;
            idx_q          <= idx_d;
            cmd_out_q      <= cmd_out_d;
            cmd_oe_q       <= cmd_oe_d;
            resp_valid_q   <= resp_valid_d;
            resp_index_q   <= resp_index_d;
            resp_arg_q     <= resp_arg_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign cmd_out      = cmd_out_q;
    assign cmd_oe       = cmd_oe_q;
    assign resp_valid   = resp_valid_q;
    assign resp_index   = resp_index_q;
    assign resp_arg     = resp_arg_q;
    assign resp_err     = resp_err_q;
    assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Randomized bench for sd_cmd_engine: a card model answers commands, a polynomial-division CRC7 model predicts results.
module tb_sd_cmd_engine;

    logic        clk;
    logic        reset_n;
    logic        tx_strobe;
    logic        rx_strobe;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  resp_type;
    logic        cmd_out;
    logic        cmd_oe;
    logic        cmd_in;
    logic        resp_valid;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        resp_err;
    logic        resp_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int sd_div   = 4;
    int ph       = 0;

    sd_cmd_engine #(.TIMEOUT_CLKS(64), .NCC_CLKS(8)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_strobe    (tx_strobe),
        .rx_strobe    (rx_strobe),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .resp_type    (resp_type),
        .cmd_out      (cmd_out),
        .cmd_oe       (cmd_oe),
        .cmd_in       (cmd_in),
        .resp_valid   (resp_valid),
        .resp_index   (resp_index),
        .resp_arg     (resp_arg),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SD clock emulation: falling-edge strobe at phase 0, rising-edge strobe mid-period.
    always @(negedge clk) begin
        tx_strobe = (ph == 0);
        rx_strobe = (ph == sd_div / 2);
        ph = (ph >= sd_div - 1) ? 0 : ph + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] m);
        logic [46:0] v;
        logic [46:0] poly;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) begin
                poly = 47'h89;
                v = v ^ (poly << (i - 7));
            end
        end
        return v[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] rsp_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b00, idx, arg, crc7_ref({2'b00, idx, arg}), 1'b1};
    endfunction

    function automatic logic exp_err(input logic [47:0] rsp, input logic [1:0] rt, input logic [5:0] idx);
        logic bad;
        bad = rsp[46] || !rsp[0];
        if (rt != 2'b10)
            bad = bad || (rsp[7:1] != crc7_ref(rsp[47:8])) || (rsp[45:40] != idx);
        return bad;
    endfunction

    task automatic handshake(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_wait_tmo", 0, 1);
        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        @(posedge clk);
        #1;
        chk("ready_fall", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
        resp_type = 2'($urandom);
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input bit reply, input logic [47:0] rsp, input int ncr,
                          output logic [47:0] frame);
        logic [47:0] got;
        logic        t, r, rel, seen, oe_bad, exp_e;
        logic [0:255] bits;
        int nbits, nrx, ntx, p, len, n;

        handshake(idx, arg, rt);
        got = '0; nbits = 0; rel = 1'b0; n = 0;
        while (!rel && n < 5000) begin
            @(posedge clk);
            t = tx_strobe;
            #1;
            if (t) begin
                if (cmd_oe) begin
                    got = {got[46:0], cmd_out};
                    nbits++;
                end else if (nbits > 0) begin
                    rel = 1'b1;
                end
            end
            n++;
        end
        if (!rel) chk("tx_release_tmo", 0, 1);
        frame = got;
        chk("tx_frame", got, cmd_frame(idx, arg));
        chk("tx_nbits", nbits, 48);
        chk("rel_out", cmd_out, 1);

        if (rt == 2'b00) begin
            chk("nr_valid", resp_valid, 1);
            chk("nr_err", resp_err, 0);
            chk("nr_tmo", resp_timeout, 0);
            exp_e = 1'b0;
        end else begin
            chk("early_valid", resp_valid, 0);
            bits = '1;
            len = 0;
            if (reply) begin
                len = ncr + 48;
                for (int i = 0; i < 48; i++) bits[ncr + i] = rsp[47 - i];
            end
            p = 0;
            cmd_in = bits[0];
            nrx = 0; seen = 1'b0; n = 0;
            while (!seen && n < 5000) begin
                @(posedge clk);
                r = rx_strobe;
                #1;
                if (r) begin
                    nrx++;
                    p++;
                    cmd_in = (p < 256) ? bits[p] : 1'b1;
                end
                if (resp_valid) seen = 1'b1;
                n++;
            end
            cmd_in = 1'b1;
            if (!seen) chk("resp_valid_tmo", 0, 1);
            if (reply) begin
                exp_e = exp_err(rsp, rt, idx);
                chk("rx_nstrobes", nrx, len);
                chk("rx_timeout", resp_timeout, 0);
                chk("rx_err", resp_err, exp_e);
                chk("rx_index", resp_index, rsp[45:40]);
                chk("rx_arg", resp_arg, rsp[39:8]);
            end else begin
                exp_e = 1'b0;
                chk("tmo_nstrobes", nrx, 64);
                chk("tmo_flag", resp_timeout, 1);
                chk("tmo_err", resp_err, 0);
            end
        end

        ntx = 0; oe_bad = 1'b0; n = 0;
        @(posedge clk);
        t = tx_strobe;
        #1;
        chk("valid_pulse", resp_valid, 0);
        forever begin
            if (cmd_oe) oe_bad = 1'b1;
            if (t) ntx++;
            if (cmd_ready || n >= 3000) break;
            @(posedge clk);
            t = tx_strobe;
            #1;
            n++;
        end
        if (!cmd_ready) chk("recover_tmo", 0, 1);
        chk("ncc_strobes", ntx, 8);
        chk("recover_oe", oe_bad, 0);
        chk("hold_err", resp_err, exp_e);
        chk("hold_tmo", resp_timeout, (rt != 2'b00 && !reply) ? 1 : 0);
    endtask

    initial begin
        logic [47:0] fr, rsp;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  rt;
        int          mode, ncr, nb;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        resp_type = '0;
        cmd_in    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_oe", cmd_oe, 0);
        chk("rst_out", cmd_out, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_valid", resp_valid, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_tmo", resp_timeout, 0);
        chk("rst_index", resp_index, 0);
        chk("rst_arg", resp_arg, 0);
        reset_n = 1'b1;

        do_cmd(6'd0, 32'h0, 2'b00, 1'b0, '0, 0, fr);
        chk("cmd0_frame", fr, 48'h400000000095);

        do_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 48'h08000001AA13, 5, fr);
        chk("cmd8_frame", fr, 48'h48000001AA87);
        chk("cmd8_err", resp_err, 0);
        chk("cmd8_arg", resp_arg, 32'h1AA);
        chk("cmd8_idx", resp_index, 6'd8);

        do_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 48'h08000001AA13 ^ 48'h4, 3, fr);
        chk("cmd8_badcrc_err", resp_err, 1);
        chk("cmd8_badcrc_arg", resp_arg, 32'h1AA);

        do_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, rsp_frame(6'd9, 32'h1AA), 2, fr);
        chk("cmd8_badidx_err", resp_err, 1);

        do_cmd(6'd41, 32'h40FF8000, 2'b10, 1'b1, 48'h3F80FF8000FF, 4, fr);
        chk("r3_err", resp_err, 0);
        chk("r3_arg", resp_arg, 32'h80FF8000);

        do_cmd(6'd55, 32'h0, 2'b01, 1'b0, '0, 0, fr);
        chk("cmd55_frame", fr, 48'h770000000065);
        chk("cmd55_tmo", resp_timeout, 1);

        // Reset in the middle of a command frame.
        handshake(6'd17, 32'hDEADBEEF, 2'b01);
        nb = 0;
        for (int k = 0; k < 5000 && nb < 20; k++) begin
            logic t;
            @(posedge clk);
            t = tx_strobe;
            #1;
            if (t && cmd_oe) nb++;
        end
        chk("mid_bits", nb, 20);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_oe", cmd_oe, 0);
        chk("mid_rst_out", cmd_out, 1);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_valid", resp_valid, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_cmd(6'd0, 32'h0, 2'b00, 1'b0, '0, 0, fr);
        chk("post_rst_frame", fr, 48'h400000000095);

        for (int it = 0; it < 30; it++) begin
            sd_div = $urandom_range(2, 6);
            idx    = 6'($urandom);
            arg    = $urandom;
            rt     = 2'($urandom);
            mode   = $urandom_range(0, 5);
            ncr    = $urandom_range(0, 20);
            rsp    = rsp_frame((mode == 2) ? idx ^ 6'($urandom_range(1, 63)) : idx, $urandom);
            if (mode == 1) rsp = rsp ^ (48'h2 << $urandom_range(0, 6));
            if (mode == 3) begin
                rsp[46] = 1'b1;
                rsp[7:1] = crc7_ref(rsp[47:8]);
            end
            if (mode == 4) rsp[0] = 1'b0;
            do_cmd(idx, arg, rt, (mode != 5) && (rt != 2'b00), rsp, ncr, fr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
